gpio_count_port: RTL and testbench
==================================

GPIO_COUNT_PORT -- requirements
Module: gpio_count_port

Interface
REQ-001 The block SHALL have parameter WIDTH, default 34: counter and data-bus width.
REQ-002 The block SHALL have port clk_i, input, 1: the single system clock, all state on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have port web_i, input, 1: pad write-enable, active-low, asynchronous to clk_i.
REQ-005 The block SHALL have port oeb_i, input, 1: pad output-enable, active-low, asynchronous to clk_i.
REQ-006 The block SHALL have port bus_i, input, WIDTH: pad data in.
REQ-007 The block SHALL have port bus_o, output, WIDTH: pad data out.
REQ-008 The block SHALL have port bus_oe_o, output, 1: pad driver enable, 1 = drive bus_o.
REQ-009 The block SHALL have port count_o, output, WIDTH: live counter value.
REQ-010 The block SHALL have port load_o, output, 1: one-cycle pulse on the cycle a load completes.

Function
REQ-011 The block SHALL pass web_i, oeb_i and bus_i through input synchronisers before use, producing web_s, oeb_s and bus_s; the synchroniser depth is set under Configuration.
REQ-012 The FSM SHALL have three states: COUNT, LOAD and READ.
REQ-013 In COUNT, the FSM SHALL go to LOAD if web_s=0, else to READ if oeb_s=0, else stay in COUNT.
REQ-014 In LOAD, the FSM SHALL go to COUNT when web_s=1.
REQ-015 In READ, the FSM SHALL go to LOAD if web_s=0, else to COUNT if oeb_s=1.
REQ-016 In COUNT and READ, the counter SHALL increment by 1 per cycle, modulo 2^WIDTH, so 2^WIDTH-1 wraps to 0 with no flag.
REQ-017 In LOAD, the counter SHALL load bus_s every cycle, so the last value sampled before web_s rises is held.
REQ-018 The counter SHALL resume incrementing on the first COUNT cycle after LOAD.
REQ-019 load_o SHALL be 1 for exactly the one cycle in which the LOAD->COUNT transition registers.
REQ-020 bus_o SHALL equal the registered counter value at all times.
REQ-021 bus_oe_o SHALL equal (state==READ) AND web_i (raw, unsynchronised).
REQ-022 When raw web_i falls, bus_oe_o SHALL drop combinationally, ahead of synchronisation, to prevent bus contention.
REQ-023 When web_s=0 and oeb_s=0 are seen together, write SHALL take priority: state LOAD, bus_oe_o=0.
REQ-024 When a web_s falling edge and a counter wrap occur in the same cycle, the load SHALL take effect on the next cycle with no increment applied.
REQ-025 count_o SHALL equal the counter register.

Reset
REQ-026 On rst_n low, the block SHALL asynchronously force: state COUNT, counter 0, synchroniser flops web=1, oeb=1, bus=0, load_o=0, bus_oe_o=0.
REQ-027 Reset de-assertion SHALL be used synchronously: counting starts on the first rising clk_i edge with rst_n high.
REQ-028 Reset asserted mid-LOAD or mid-READ SHALL abort the operation with no partial load retained.

Configuration
REQ-029 With macro GPIO_SYNC_2FF_EN defined, every synchronised input SHALL use two flip-flop stages.
REQ-030 With GPIO_SYNC_2FF_EN defined, the latency from a raw web_i or oeb_i edge to the state change SHALL be 3 rising edges.
REQ-031 With GPIO_SYNC_2FF_EN undefined, every synchronised input SHALL use a single register stage.
REQ-032 With GPIO_SYNC_2FF_EN undefined, that latency SHALL be 2 rising edges.
REQ-033 All other behaviour SHALL be identical with and without GPIO_SYNC_2FF_EN.

Verification
REQ-034 The bench SHALL cover reset and free-run: release rst_n, web=1, oeb=1, 10 cycles -> count_o=9 or 10 (edge-counting per REQ-027), bus_oe_o=0 throughout.
REQ-035 The bench SHALL cover load: web=0 with bus_i=34'h2_0000_0005 for 6 cycles, then web=1 -> load_o pulses once, then count_o steps 34'h2_0000_0005, 34'h2_0000_0006, ...
REQ-036 The bench SHALL cover wrap: load 34'h3_FFFF_FFFE, release -> count_o goes 3_FFFF_FFFE, 3_FFFF_FFFF, 0, 1.
REQ-037 The bench SHALL cover read: oeb=0, web=1 -> bus_oe_o=1 after sync latency, and bus_o tracks count_o every cycle.
REQ-038 The bench SHALL cover read-to-write turnaround: in READ, drop web -> bus_oe_o=0 in the same cycle, state LOAD after sync latency, and the count loads from bus_i.
REQ-039 The bench SHALL cover reset mid-load: rst_n=0 during LOAD -> count_o=0 and bus_oe_o=0 immediately, state COUNT after release.

Source files
------------

// File: rtl/gpio_count_port.sv
// GPIO pad port with a free-running counter, pad write (load) and pad read.
// Define GPIO_SYNC_2FF_EN for two-stage input synchronisers (default: one stage).
module gpio_count_port #(
  parameter int WIDTH = 34
) (
  input  logic             clk_i,
  input  logic             rst_n,
  input  logic             web_i,
  input  logic             oeb_i,
  input  logic [WIDTH-1:0] bus_i,
  output logic [WIDTH-1:0] bus_o,
  output logic             bus_oe_o,
  output logic [WIDTH-1:0] count_o,
  output logic             load_o
);

  typedef enum logic [1:0] {
    COUNT = 2'd0,
    LOAD  = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t           state;
  logic             web_s;
  logic             oeb_s;
  logic [WIDTH-1:0] bus_s;
  logic [WIDTH-1:0] count;

`ifdef GPIO_SYNC_2FF_EN
  logic             web_m;
  logic             oeb_m;
  logic [WIDTH-1:0] bus_m;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      web_m <= 1'b1;
      oeb_m <= 1'b1;
      bus_m <= '0;
      web_s <= 1'b1;
      oeb_s <= 1'b1;
      bus_s <= '0;
    end else begin
      web_m <= web_i;
      oeb_m <= oeb_i;
      bus_m <= bus_i;
      web_s <= web_m;
      oeb_s <= oeb_m;
      bus_s <= bus_m;
    end
  end
`else
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      web_s <= 1'b1;
      oeb_s <= 1'b1;
      bus_s <= '0;
    end else begin
      web_s <= web_i;
      oeb_s <= oeb_i;
      bus_s <= bus_i;
    end
  end
`endif

  // Write always wins over read; LOAD keeps sampling the bus until web_s rises.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state  <= COUNT;
      count  <= '0;
      load_o <= 1'b0;
    end else begin
      load_o <= 1'b0;
      case (state)
        COUNT: begin
          count <= count + WIDTH'(1);
          if (!web_s) begin
            state <= LOAD;
          end else if (!oeb_s) begin
            state <= READ;
          end
        end
        LOAD: begin
          count <= bus_s;
          if (web_s) begin
            state  <= COUNT;
            load_o <= 1'b1;
          end
        end
        READ: begin
          count <= count + WIDTH'(1);
          if (!web_s) begin
            state <= LOAD;
          end else if (oeb_s) begin
            state <= COUNT;
          end
        end
        default: state <= COUNT;
      endcase
    end
  end

  // Raw web_i gates the driver so a pad write releases the bus before sync.
  assign bus_oe_o = (state == READ) && web_i;
  assign bus_o    = count;
  assign count_o  = count;

endmodule

// File: tb/tb_gpio_count_port.sv
// Self-checking bench for gpio_count_port using an expected-value queue.
// Honours GPIO_SYNC_2FF_EN for the synchroniser latency.
module tb_gpio_count_port;

  localparam int W = 34;
`ifdef GPIO_SYNC_2FF_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 1;
`endif

  logic         clk_i = 1'b0;
  logic         rst_n;
  logic         web_i;
  logic         oeb_i;
  logic [W-1:0] bus_i;
  logic [W-1:0] bus_o;
  logic         bus_oe_o;
  logic [W-1:0] count_o;
  logic         load_o;

  int tests = 0;
  int fails = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] read_base;

  gpio_count_port #(.WIDTH(W)) dut (
    .clk_i    (clk_i),
    .rst_n    (rst_n),
    .web_i    (web_i),
    .oeb_i    (oeb_i),
    .bus_i    (bus_i),
    .bus_o    (bus_o),
    .bus_oe_o (bus_oe_o),
    .count_o  (count_o),
    .load_o   (load_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Drives a pad write of v for hold cycles, then waits (bounded) for load_o.
  task automatic drive_load(input logic [W-1:0] v, input int hold, output bit seen);
    web_i = 1'b0;
    bus_i = v;
    repeat (hold) tick();
    web_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (load_o === 1'b1) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    logic [W-1:0] e;
    rst_n = 1'b0;
    web_i = 1'b1;
    oeb_i = 1'b1;
    bus_i = '0;
    #3;
    tests++;
    if (count_o !== '0 || bus_oe_o !== 1'b0 || load_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_state count=%h oe=%b load=%b required 0/0/0", count_o, bus_oe_o, load_o);
    end
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) exp_q.push_back(W'(n));
    for (int n = 1; n <= 10; n++) begin
      tick();
      e = exp_q.pop_front();
      tests++;
      if (count_o !== e || bus_oe_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL free_run cycle %0d count=%h oe=%b required %h/0", n, count_o, bus_oe_o, e);
      end
    end
  endtask

  task automatic test_load();
    bit seen;
    logic [W-1:0] v = 34'h2_0000_0005;
    logic [W-1:0] e;
    drive_load(v, 6, seen);
    tests++;
    if (!seen || count_o !== v) begin
      fails++;
      $display("[TB] FAIL load_pulse seen=%b count=%h required 1/%h", seen, count_o, v);
    end
    for (int n = 1; n <= 3; n++) exp_q.push_back(v + W'(n));
    for (int n = 1; n <= 3; n++) begin
      tick();
      e = exp_q.pop_front();
      tests++;
      if (count_o !== e || load_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL load_resume count=%h load=%b required %h/0", count_o, load_o, e);
      end
    end
  endtask

  task automatic test_wrap();
    bit seen;
    logic [W-1:0] e;
    drive_load(34'h3_FFFF_FFFE, 4, seen);
    exp_q.push_back(34'h3_FFFF_FFFE);
    exp_q.push_back(34'h3_FFFF_FFFF);
    exp_q.push_back(34'h0_0000_0000);
    exp_q.push_back(34'h0_0000_0001);
    tests++;
    if (!seen) begin
      fails++;
      $display("[TB] FAIL wrap_load_pulse seen=%b required 1", seen);
    end
    for (int n = 0; n < 4; n++) begin
      if (n > 0) tick();
      e = exp_q.pop_front();
      tests++;
      if (count_o !== e) begin
        fails++;
        $display("[TB] FAIL wrap step %0d count=%h required %h", n, count_o, e);
      end
    end
  endtask

  task automatic test_read();
    bit seen;
    logic [W-1:0] v = 34'h1_2345_0000;
    logic [W-1:0] e;
    logic exp_oe;
    drive_load(v, 3, seen);
    tests++;
    if (!seen || count_o !== v) begin
      fails++;
      $display("[TB] FAIL read_setup seen=%b count=%h required 1/%h", seen, count_o, v);
    end
    oeb_i = 1'b0;
    for (int n = 1; n <= 8; n++) exp_q.push_back(v + W'(n));
    for (int n = 1; n <= 8; n++) begin
      tick();
      e = exp_q.pop_front();
      exp_oe = (n >= SYNC + 1);
      tests++;
      if (count_o !== e || bus_o !== e || bus_oe_o !== exp_oe) begin
        fails++;
        $display("[TB] FAIL read cycle %0d count=%h bus=%h oe=%b required %h/%h/%b",
                 n, count_o, bus_o, bus_oe_o, e, e, exp_oe);
      end
    end
    read_base = v + W'(8);
  endtask

  task automatic test_back_to_back();
    bit seen;
    logic [W-1:0] wv = 34'h0_5A5A_0F0F;
    logic [W-1:0] e;
    tests++;
    if (bus_oe_o !== 1'b1) begin
      fails++;
      $display("[TB] FAIL turn_pre_oe oe=%b required 1", bus_oe_o);
    end
    web_i = 1'b0;
    bus_i = wv;
    #1;
    tests++;
    if (bus_oe_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL turn_oe_comb oe=%b required 0", bus_oe_o);
    end
    for (int m = 1; m <= SYNC + 1; m++) exp_q.push_back(read_base + W'(m));
    for (int m = 0; m < 3; m++) exp_q.push_back(wv);
    for (int m = 1; m <= SYNC + 4; m++) begin
      tick();
      e = exp_q.pop_front();
      tests++;
      if (count_o !== e || bus_oe_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL turn cycle %0d count=%h oe=%b required %h/0", m, count_o, bus_oe_o, e);
      end
    end
    oeb_i = 1'b1;
    web_i = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (load_o === 1'b1) seen = 1'b1;
    end
    tests++;
    if (!seen || count_o !== wv) begin
      fails++;
      $display("[TB] FAIL turn_load_done seen=%b count=%h required 1/%h", seen, count_o, wv);
    end
  endtask

  task automatic test_reset_mid_load();
    bit in_load = 1'b0;
    logic [W-1:0] x = 34'h0_ABCD_1234;
    logic [W-1:0] e;
    web_i = 1'b0;
    bus_i = x;
    for (int i = 0; i < 10 && !in_load; i++) begin
      tick();
      if (count_o === x) in_load = 1'b1;
    end
    tests++;
    if (!in_load) begin
      fails++;
      $display("[TB] FAIL midload_enter count=%h required %h", count_o, x);
    end
    #1;
    rst_n = 1'b0;
    #1;
    tests++;
    if (count_o !== '0 || bus_oe_o !== 1'b0 || load_o !== 1'b0) begin
      fails++;
      $display("[TB] FAIL midload_reset count=%h oe=%b load=%b required 0/0/0", count_o, bus_oe_o, load_o);
    end
    web_i = 1'b1;
    tick();
    tick();
    rst_n = 1'b1;
    for (int n = 1; n <= 3; n++) exp_q.push_back(W'(n));
    for (int n = 1; n <= 3; n++) begin
      tick();
      e = exp_q.pop_front();
      tests++;
      if (count_o !== e || load_o !== 1'b0 || bus_oe_o !== 1'b0) begin
        fails++;
        $display("[TB] FAIL midload_after cycle %0d count=%h load=%b oe=%b required %h/0/0",
                 n, count_o, load_o, bus_oe_o, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_wrap();
    test_read();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
